// File: rtl/execute_writeback.sv
// Multi-cycle execute/writeback stage: single-cycle ALU ops, iterative shifts,
// one-cycle register-file write strobe and a reject pulse for bad instructions.
module execute_writeback #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid,
   input  logic [6:0]      opcode,
   input  logic [3:0]      func,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic            hata,
   output logic            busy,
   output logic            we,
   output logic [XLEN-1:0] rd_data,
   output logic            hata_out
);
   localparam int unsigned    SHW    = $clog2(XLEN);
   localparam logic [SHW-1:0] STEP   = SHW'(SHIFT_STEP);
   localparam logic [6:0]     OP_R   = 7'b0110011;
   localparam logic [6:0]     OP_I   = 7'b0010011;
   localparam logic [6:0]     OP_LUI = 7'b0110111;

   typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] rd_data_q, rd_data_d;
   logic [SHW-1:0]  shamt_q, shamt_d;
   logic            left_q, left_d;
   logic            arith_q, arith_d;
   logic            hata_q, hata_d;

   logic            is_r, is_i, is_lui, is_shift, reject;
   logic [XLEN-1:0] op_b, alu, shifted;
   logic [SHW-1:0]  shamt_in, step;

   always_comb begin
      is_r     = (opcode == OP_R);
      is_i     = (opcode == OP_I);
      is_lui   = (opcode == OP_LUI);
      op_b     = is_r ? rs2_data : imm;
      shamt_in = op_b[SHW-1:0];
      is_shift = !is_lui && (func[1:0] == 2'b01);
      reject   = hata || !(is_r || is_i || is_lui) ||
                 (is_i && (func[2:0] == 3'b001) && (imm[11:5] != '0));
      alu      = '0;
      if (is_lui) begin
         alu = imm;
      end else begin
         case (func[2:0])
            3'b000: alu = (is_r && func[3]) ? rs1_data - op_b : rs1_data + op_b;
            // Shifts only complete here when the amount is zero
            3'b001: alu = rs1_data;
            3'b101: alu = rs1_data;
            3'b010: alu = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            3'b011: alu = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
            3'b100: alu = rs1_data ^ op_b;
            3'b110: alu = rs1_data | op_b;
            3'b111: alu = rs1_data & op_b;
            default: alu = '0;
         endcase
      end
   end

   always_comb begin
      step    = (shamt_q < STEP) ? shamt_q : STEP;
      shifted = '0;
      if (left_q)       shifted = result_q << step;
      else if (arith_q) shifted = $signed(result_q) >>> step;
      else              shifted = result_q >> step;
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      rd_data_d = rd_data_q;
      shamt_d   = shamt_q;
      left_d    = left_q;
      arith_d   = arith_q;
      hata_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid) begin
               if (reject) begin
                  hata_d = 1'b1;
               end else if (is_shift && (shamt_in != '0)) begin
                  result_d = rs1_data;
                  shamt_d  = shamt_in;
                  left_d   = (func[2:0] == 3'b001);
                  arith_d  = func[3];
                  state_d  = SHIFT;
               end else begin
                  result_d  = alu;
                  rd_data_d = alu;
                  state_d   = WB;
               end
            end
         end
         SHIFT: begin
            result_d = shifted;
            shamt_d  = shamt_q - step;
            if (shamt_q == step) begin
               rd_data_d = shifted;
               state_d   = WB;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         result_q  <= '0;
         rd_data_q <= '0;
         shamt_q   <= '0;
         left_q    <= 1'b0;
         arith_q   <= 1'b0;
         hata_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         rd_data_q <= rd_data_d;
         shamt_q   <= shamt_d;
         left_q    <= left_d;
         arith_q   <= arith_d;
         hata_q    <= hata_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign we       = (state_q == WB);
   assign rd_data  = rd_data_q;
   assign hata_out = hata_q;
endmodule
